chan_scheduler: RTL and testbench
=================================

Name: chan_scheduler

Overview:
- Round-robin time-division scheduler that shares the single Gilbert channel-model instance between N_REQ transmitter streams.
- Grants one requester at a time for a frame of up to FRAME_LEN samples, forwards that requester's samples to the channel input, and inserts a guard gap between frames.
- Sits directly upstream of the channel model. The channel model's state output is fed back to this block.

Parameters:
- N_REQ, 4, number of requesting transmitters (2..8).
- FRAME_LEN, 16, max samples accepted per grant (1..65535).
- GUARD_CYC, 2, idle cycles between frames (0..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester frame request, level.
- s_valid  in  N_REQ  per-requester sample valid.
- s_data  in  16*N_REQ  per-requester signed samples; requester i occupies bits [16i+15:16i].
- s_ready  out  N_REQ  per-requester ready; only the granted bit can be high.
- chan_state  in  1  channel-model state (0 = Good, 1 = Bad).
- m_data  out  16  signed sample to the channel input.
- m_valid  out  1  m_data valid.
- grant  out  N_REQ  one-hot current grant; all zero when not in GRANT.
- busy  out  1  high in GRANT or GUARD.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_cnt  out  16  samples accepted in the frame just ended; held until the next frame_done.

Behaviour:
- Reset (reset = 0):
  - State IDLE; grant, s_ready, m_valid, busy, frame_done = 0.
  - m_data = 0, frame_cnt = 0.
  - Round-robin pointer = 0; internal sample counter = 0, guard counter = 0.
  - Reset asserted mid-frame aborts immediately. No frame_done is issued for the aborted frame.
- FSM states: IDLE, GRANT, GUARD.
- IDLE:
  - If req != 0, select the first set req bit at or above the pointer, wrapping modulo N_REQ.
  - Register the grant; enter GRANT on the next edge.
  - Pointer becomes (winner + 1) mod N_REQ.
  - Arbitration takes exactly one cycle in IDLE.
- GRANT:
  - s_ready = grant, decoded combinationally from the grant register.
  - Handshake: a sample is accepted when s_valid[g] && s_ready[g].
  - On acceptance: m_data <= s_data[g], m_valid <= 1, counter++.
  - Output latency is 1 cycle. m_valid = 0 in every cycle without acceptance.
- Frame end, evaluated each GRANT cycle:
  - (a) Full: the acceptance that brings the counter to FRAME_LEN ends the frame.
  - (b) Abort: req[g] = 0 ends the frame. A sample accepted in that same cycle is still forwarded and counted.
  - If (a) and (b) coincide, the frame counts as full.
  - On frame end: frame_done = 1 for one cycle (the cycle after the ending edge), frame_cnt <= final count, grant <= 0, counter <= 0.
  - Next state is GUARD if GUARD_CYC > 0, otherwise IDLE.
- GUARD:
  - Count GUARD_CYC cycles with grant = 0 and m_valid = 0, then return to IDLE.
  - req changes during GUARD are ignored until IDLE.
- busy = (state != IDLE).
- Minimum frame-to-frame spacing: one end cycle + GUARD_CYC + one IDLE arbitration cycle.
- A requester holding req high continuously is re-granted only after all other active requesters have been served (fairness).
- s_valid and s_data from non-granted requesters are ignored.
- The counter width covers FRAME_LEN without wrap. frame_cnt is zero-extended to 16 bits.
- Without the optional feature, chan_state is unused.

Optional Feature:
- Macro: CHAN_BAD_HOLDOFF_EN.
- Defined:
  - In IDLE, no new grant is issued while chan_state = 1. The pointer is unchanged while holding off.
  - An in-progress frame is never interrupted by chan_state.
  - Arbitration resumes in the first IDLE cycle with chan_state = 0.
- Not defined: chan_state is ignored; arbitration proceeds regardless of channel state.

Test Plan:
- Reset: hold reset = 0 with req = 4'b1111 -> grant = 0, m_valid = 0, busy = 0, frame_cnt = 0. Release reset -> grant = 4'b0001 one cycle after the first IDLE cycle.
- Full frame: FRAME_LEN = 16, req[2] only, s_valid[2] = 1, s_data[2] = 16'sd100 + n:
  - m_data = 100..115 with 1-cycle latency.
  - frame_done pulses once, frame_cnt = 16.
  - grant = 0 for GUARD_CYC = 2 cycles.
- Round-robin: req = 4'b1011 held, FRAME_LEN = 4 -> grant sequence 0001, 0010, 1000, 0001, each frame_cnt = 4.
- Abort: req[1] drops after 5 accepted samples -> frame_done, frame_cnt = 5. Abort coincident with the 16th acceptance -> frame_cnt = 16.
- Backpressure/gaps: s_valid[0] toggles 1,0,1,0 -> m_valid follows one cycle later; counter increments only on acceptance; s_ready[3] stays 0 throughout.
- CHAN_BAD_HOLDOFF_EN defined, chan_state = 1 for 10 cycles in IDLE with req = 4'b0100 -> grant stays 0. Grant = 4'b0100 one cycle after chan_state falls. chan_state rising mid-frame leaves the frame intact.

Source files
------------

// File: rtl/chan_scheduler.sv
// chan_scheduler
//   Round-robin time-division scheduler sharing one Gilbert channel-model
//   instance between N_REQ transmitter streams. One requester is granted at a
//   time for a frame of up to FRAME_LEN samples. Its samples are forwarded to
//   the channel input with one cycle of latency. GUARD_CYC idle cycles are
//   inserted after every frame.
//
// Optional feature macro: CHAN_BAD_HOLDOFF_EN
//   When defined, no new grant is issued in IDLE while chan_state = 1. The
//   round-robin pointer is also left unchanged while holding off. A frame that
//   is already in progress is never interrupted by chan_state.
//   When undefined, chan_state is ignored.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   req         in   [N_REQ]     per-requester frame request (level)
//   s_valid     in   [N_REQ]     per-requester sample valid
//   s_data      in   [16*N_REQ]  per-requester signed samples, requester i at [16i+15:16i]
//   s_ready     out  [N_REQ]     per-requester ready (only the granted bit can be high)
//   chan_state  in   channel-model state (0 = Good, 1 = Bad)
//   m_data      out  [16]        sample to the channel input
//   m_valid     out  m_data valid
//   grant       out  [N_REQ]     one-hot grant, zero outside GRANT
//   busy        out  high in GRANT or GUARD
//   frame_done  out  one-cycle pulse after the frame-ending edge
//   frame_cnt   out  [16]        samples accepted in the last completed frame
module chan_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   s_valid,
  input  logic [16*N_REQ-1:0] s_data,
  output logic [N_REQ-1:0]   s_ready,
  input  logic               chan_state,
  output logic [15:0]        m_data,
  output logic               m_valid,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic [7:0]       GUARD_LAST = 8'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   w_grant_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [7:0]         r_guard;
  logic [7:0]         w_guard_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [15:0]        r_fcnt;
  logic [15:0]        w_fcnt_nxt;
  logic [15:0]        r_mdata;
  logic               r_mvalid;

  logic               w_hold;
  logic               w_req_any;
  logic [2*N_REQ-1:0] w_req_sh;
  logic               w_found;
  logic [N_REQ-1:0]   w_win_oh;
  logic [PTR_W-1:0]   w_ptr_after;
  logic [15:0]        w_gdata;
  logic               w_accept;
  logic               w_full;
  logic               w_abort;

`ifdef CHAN_BAD_HOLDOFF_EN
  assign w_hold = chan_state;
`else
  logic w_unused_chan_state;
  assign w_unused_chan_state = chan_state;
  assign w_hold              = 1'b0;
`endif

  assign w_req_any = |req;

  // Rotate the request vector so that bit 0 is the requester at the pointer.
  // The first set bit k then gives winner = (ptr + k) mod N_REQ.
  assign w_req_sh = {req, req} >> r_ptr;

  always_comb begin : arb
    int unsigned v_win;
    v_win       = 0;
    w_found     = 1'b0;
    w_win_oh    = '0;
    w_ptr_after = r_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && w_req_sh[k]) begin
        w_found = 1'b1;
        v_win   = int'(r_ptr) + k;
        if (v_win >= N_REQ) begin
          v_win = v_win - N_REQ;
        end
      end
    end
    if (w_found) begin
      w_win_oh    = N_REQ'(1) << v_win;
      w_ptr_after = (v_win + 1 >= N_REQ) ? '0 : PTR_W'(v_win + 1);
    end
  end

  // Mux the granted requester's sample. r_grant is one-hot or zero.
  always_comb begin
    w_gdata = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_grant[k]) begin
        w_gdata = s_data[16*k +: 16];
      end
    end
  end

  assign w_accept = (r_state == ST_GRANT) && (|(s_valid & r_grant));
  assign w_full   = w_accept && (r_cnt == CNT_LAST);
  assign w_abort  = ~|(req & r_grant);

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_guard_nxt = r_guard;
    w_done_nxt  = 1'b0;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any && !w_hold) begin
          w_grant_nxt = w_win_oh;
          w_ptr_nxt   = w_ptr_after;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_cnt_nxt = r_cnt + CNT_W'(w_accept);
        // A sample accepted in the abort cycle is still counted, so a
        // coincident full/abort always reports the full count.
        if (w_full || w_abort) begin
          w_done_nxt  = 1'b1;
          w_fcnt_nxt  = 16'(w_cnt_nxt);
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_guard_nxt = '0;
          w_state_nxt = (GUARD_CYC > 0) ? ST_GUARD : ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (r_guard == GUARD_LAST) begin
          w_guard_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_guard_nxt = r_guard + 8'd1;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
        w_guard_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_guard  <= '0;
      r_done   <= 1'b0;
      r_fcnt   <= '0;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
    end else begin
      r_grant  <= w_grant_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_guard  <= w_guard_nxt;
      r_done   <= w_done_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_mvalid <= w_accept;
      if (w_accept) begin
        r_mdata <= w_gdata;
      end
    end
  end

  assign grant      = r_grant;
  assign s_ready    = r_grant;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_done;
  assign frame_cnt  = r_fcnt;
  assign m_data     = r_mdata;
  assign m_valid    = r_mvalid;

endmodule

// File: tb/tb_chan_scheduler.sv
module tb_chan_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  sv;
  logic [63:0] sd;
  logic        chan_state;

  logic [3:0]  s_ready, grant;
  logic [15:0] m_data, frame_cnt;
  logic        m_valid, busy, frame_done;

  logic [3:0]  d4_s_ready, d4_grant;
  logic [15:0] d4_m_data, d4_frame_cnt;
  logic        d4_m_valid, d4_busy, d4_frame_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chan_scheduler u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .s_valid    (sv),
    .s_data     (sd),
    .s_ready    (s_ready),
    .chan_state (chan_state),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .grant      (grant),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  chan_scheduler #(.N_REQ(4), .FRAME_LEN(4), .GUARD_CYC(0)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .s_valid    (sv),
    .s_data     (sd),
    .s_ready    (d4_s_ready),
    .chan_state (chan_state),
    .m_data     (d4_m_data),
    .m_valid    (d4_m_valid),
    .grant      (d4_grant),
    .busy       (d4_busy),
    .frame_done (d4_frame_done),
    .frame_cnt  (d4_frame_cnt)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  sv;
    logic [15:0] d0;
    logic [3:0]  e_grant;
    logic        e_mv;
    logic [15:0] e_md;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_fcnt;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req        = '0;
    sv         = '0;
    sd         = '0;
    chan_state = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [3:0] rr_exp [4];
  logic [15:0] md_got, md_exp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset ----------------
    reset      = 1'b0;
    req        = 4'b1111;
    sv         = '0;
    sd         = '0;
    chan_state = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          {grant, s_ready, m_valid, busy, frame_done, frame_cnt, m_data},
          {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0});
    reset = 1'b1;
    #1;
    check("release_no_grant_yet", {60'd0, grant}, 64'h0);
    tick();
    check("first_grant", {busy, grant}, {1'b1, 4'b0001});

    // ---------------- table: gaps, backpressure, abort, guard ----------------
    tbl[0] = '{4'b0001, 4'b1001, 16'h0000, 4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{4'b0001, 4'b1001, 16'h0011, 4'b0001, 1'b1, 16'h0011, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{4'b0001, 4'b1000, 16'h0044, 4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{4'b0001, 4'b1001, 16'h0022, 4'b0001, 1'b1, 16'h0022, 1'b1, 1'b0, 16'd0};
    tbl[4] = '{4'b0001, 4'b1000, 16'h0055, 4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd0};
    tbl[5] = '{4'b0000, 4'b1001, 16'h0033, 4'b0000, 1'b1, 16'h0033, 1'b1, 1'b1, 16'd3};
    tbl[6] = '{4'b0001, 4'b1000, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd3};
    tbl[7] = '{4'b0001, 4'b1000, 16'h0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd3};
    tbl[8] = '{4'b0001, 4'b1000, 16'h0000, 4'b0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'd3};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      req      = tbl[i].req;
      sv       = tbl[i].sv;
      sd       = '0;
      sd[15:0] = tbl[i].d0;
      sd[63:48] = 16'hBEEF;
      tick();
      md_got = tbl[i].e_mv ? m_data : 16'h0;
      md_exp = tbl[i].e_mv ? tbl[i].e_md : 16'h0;
      check($sformatf("vec%0d", i),
            {grant, s_ready, m_valid, md_got, busy, frame_done, frame_cnt},
            {tbl[i].e_grant, tbl[i].e_grant, tbl[i].e_mv, md_exp,
             tbl[i].e_busy, tbl[i].e_done, tbl[i].e_fcnt});
    end

    // ---------------- full frame on requester 2 ----------------
    do_reset();
    req = 4'b0100;
    sv  = 4'b0100;
    sd[47:32] = 16'd100;
    tick();
    check("full_grant", {60'd0, grant}, {60'd0, 4'b0100});
    for (int n = 0; n < 16; n++) begin
      sd[47:32] = 16'(100 + n);
      tick();
      check($sformatf("full_sample%0d", n), {m_valid, m_data, frame_done},
            {1'b1, 16'(100 + n), (n == 15)});
    end
    check("full_end", {grant, frame_cnt, busy}, {4'b0000, 16'd16, 1'b1});
    tick();
    check("guard1", {grant, m_valid, busy, frame_done}, {4'b0000, 1'b0, 1'b1, 1'b0});
    tick();
    check("idle_after_guard", {grant, m_valid, busy, frame_done}, {4'b0000, 1'b0, 1'b0, 1'b0});
    tick();
    check("regrant_after_guard", {grant, frame_cnt}, {4'b0100, 16'd16});

    // ---------------- round robin (FRAME_LEN=4, no guard) ----------------
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    do_reset();
    req = 4'b1011;
    sv  = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      tick();
      check($sformatf("rr_grant%0d", f), {60'd0, d4_grant}, {60'd0, rr_exp[f]});
      repeat (3) tick();
      tick();
      check($sformatf("rr_end%0d", f), {d4_grant, d4_frame_done, d4_frame_cnt},
            {4'b0000, 1'b1, 16'd4});
    end

    // ---------------- abort after 5 samples ----------------
    do_reset();
    req = 4'b0010;
    sv  = 4'b0010;
    tick();
    repeat (5) tick();
    check("abort_pre", {frame_done, grant}, {1'b0, 4'b0010});
    req = 4'b0000;
    sv  = 4'b0000;
    tick();
    check("abort5", {frame_done, frame_cnt, grant, m_valid}, {1'b1, 16'd5, 4'b0000, 1'b0});

    // ---------------- abort coincident with 16th acceptance ----------------
    do_reset();
    req = 4'b0010;
    sv  = 4'b0010;
    tick();
    repeat (15) tick();
    check("coinc_pre", {60'd0, frame_done, grant}, {60'd0, 1'b0, 4'b0010});
    req = 4'b0000;
    tick();
    check("coinc_full", {frame_done, frame_cnt, m_valid}, {1'b1, 16'd16, 1'b1});

    // ---------------- reset mid-frame ----------------
    do_reset();
    req = 4'b0001;
    sv  = 4'b0001;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("async_abort", {busy, grant, m_valid, frame_done}, {1'b0, 4'b0000, 1'b0, 1'b0});
    req = 4'b0000;
    reset = 1'b1;
    tick();
    tick();
    check("no_done_after_abort", {frame_done, frame_cnt, busy}, {1'b0, 16'd0, 1'b0});

`ifdef CHAN_BAD_HOLDOFF_EN
    // ---------------- channel-bad holdoff ----------------
    do_reset();
    chan_state = 1'b1;
    req        = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("holdoff%0d", c), {busy, grant}, {1'b0, 4'b0000});
    end
    chan_state = 1'b0;
    tick();
    check("holdoff_release", {60'd0, grant}, {60'd0, 4'b0100});
    sv         = 4'b0100;
    chan_state = 1'b1;
    repeat (15) tick();
    check("bad_midframe_intact", {frame_done, grant}, {1'b0, 4'b0100});
    tick();
    check("bad_midframe_end", {frame_done, frame_cnt}, {1'b1, 16'd16});
    chan_state = 1'b0;
`else
    // ---------------- chan_state ignored ----------------
    do_reset();
    chan_state = 1'b1;
    req        = 4'b0100;
    tick();
    check("chan_ignored", {60'd0, grant}, {60'd0, 4'b0100});
    chan_state = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
